// File: rtl/pe_cfg_loader.sv
// Streams 4-bit config nibbles into a shadow bank of per-PE control words,
// commits the full set atomically to the active bank, and drives the shared PE enable.
module pe_cfg_loader #(
    parameter int NUM_PE = 4,
    parameter int CTRL_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_data,
    input  logic                     run_en,
    input  logic                     step,
    output logic [CTRL_W*NUM_PE-1:0] ctrl_out,
    output logic                     pe_en,
    output logic                     configured,
    output logic                     cfg_done,
    output logic                     busy
);

    localparam int NIB   = 2 * NUM_PE;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CTRL_W*NUM_PE-1:0]  shadow_q;
    logic [CTRL_W*NUM_PE-1:0]  shadow_d;
    logic [CTRL_W*NUM_PE-1:0]  active_q;
    logic                      configured_q;
    logic                      cfg_done_q;
    logic                      step_q;
    logic                      hs;
    logic                      step_pulse;

    // A restart takes priority, so a nibble offered alongside it is not taken.
    assign in_ready = (state_q == LOAD) & ~cfg_start;
    assign hs       = in_valid & in_ready;

    // Even counts fill the high nibble, so slot index is the count with bit 0 flipped.
    always_comb begin
        shadow_d = shadow_q;
        for (int n = 0; n < NIB; n++) begin
            if (hs && ((32'(cnt_q) ^ 32'd1) == 32'(n))) begin
                shadow_d[4*n +: 4] = in_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            configured_q <= 1'b0;
            cfg_done_q   <= 1'b0;
            step_q       <= 1'b0;
        end else begin
            step_q     <= step;
            cfg_done_q <= 1'b0;
            shadow_q   <= shadow_d;
            unique case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        cnt_q <= '0;
                    end else if (hs) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= COMMIT;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    active_q     <= shadow_q;
                    configured_q <= 1'b1;
                    cfg_done_q   <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign step_pulse = step & ~step_q;
    assign pe_en      = configured_q & (run_en | step_pulse);
    assign ctrl_out   = active_q;
    assign configured = configured_q;
    assign cfg_done   = cfg_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Directed bench for pe_cfg_loader: vector table for a plain load,
// then hand sequences for reset abort, backpressure, overlap, restart and step.
module tb_pe_cfg_loader;

    logic        clock;
    logic        reset;
    logic        cfg_start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        run_en;
    logic        step;
    logic [31:0] ctrl_out;
    logic        pe_en;
    logic        configured;
    logic        cfg_done;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic cfg_m = 1'b0;

    pe_cfg_loader #(.NUM_PE(4), .CTRL_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .run_en     (run_en),
        .step       (step),
        .ctrl_out   (ctrl_out),
        .pe_en      (pe_en),
        .configured (configured),
        .cfg_done   (cfg_done),
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        cs;
        logic        iv;
        logic [3:0]  d;
        logic        rdy;
        logic        pe;
        logic        bsy;
        logic        done;
        logic        cfgd;
        logic [31:0] ctrl;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_seq(input logic do_start, input logic [31:0] seq,
                            input int gap, input logic run,
                            input logic [31:0] old_w, input logic [31:0] new_w);
        int idx;
        int ph;
        int cyc;
        if (do_start) begin
            @(negedge clock);
            cfg_start = 1'b1;
            in_valid  = 1'b0;
            run_en    = run;
            #1;
            chk("idle_rdy", in_ready, 0);
            chk("idle_busy", busy, 0);
            chk("idle_pe_en", pe_en, run & cfg_m);
        end
        idx = 0;
        ph  = 0;
        cyc = 0;
        while (idx < 8 && cyc < 200) begin
            @(negedge clock);
            cfg_start = 1'b0;
            run_en    = run;
            in_valid  = (ph == 0);
            in_data   = in_valid ? seq[31-4*idx -: 4] : 4'hE;
            #1;
            chk($sformatf("load_rdy[%0d]", cyc), in_ready, 1);
            chk($sformatf("load_busy[%0d]", cyc), busy, 1);
            chk($sformatf("load_ctrl_hold[%0d]", cyc), ctrl_out, old_w);
            chk($sformatf("load_pe_en[%0d]", cyc), pe_en, run & cfg_m);
            chk($sformatf("load_done[%0d]", cyc), cfg_done, 0);
            if (in_valid) idx++;
            ph = (ph == gap) ? 0 : ph + 1;
            cyc++;
        end
        if (idx < 8) chk("load_timeout", idx, 8);
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 4'h9;
        #1;
        chk("commit_rdy", in_ready, 0);
        chk("commit_busy", busy, 1);
        chk("commit_ctrl_hold", ctrl_out, old_w);
        chk("commit_done", cfg_done, 0);
        chk("commit_pe_en", pe_en, run & cfg_m);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk("post_ctrl", ctrl_out, new_w);
        chk("post_done", cfg_done, 1);
        chk("post_busy", busy, 0);
        chk("post_cfgd", configured, 1);
        chk("post_pe_en", pe_en, run);
        cfg_m = 1'b1;
        @(negedge clock);
        #1;
        chk("post2_done", cfg_done, 0);
        chk("post2_ctrl", ctrl_out, new_w);
    endtask

    logic [31:0] seq_a;
    logic [6:0]  step_exp;

    initial begin
        reset     = 1'b0;
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        run_en    = 1'b1;
        step      = 1'b0;
        seq_a     = 32'hA53C0FF0;

        tbl[0]  = '{1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        for (int i = 1; i <= 8; i++) begin
            tbl[i] = '{1'b0, 1'b1, seq_a[35-4*i -: 4], 1'b1, 1'b0, 1'b1,
                       1'b0, 1'b0, 32'h0};
        end
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                    32'hF00F3CA5};
        tbl[11] = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                    32'hF00F3CA5};

        #1;
        chk("rst_ctrl", ctrl_out, 0);
        chk("rst_pe_en", pe_en, 0);
        chk("rst_cfgd", configured, 0);
        chk("rst_rdy", in_ready, 0);
        #11 reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            cfg_start = tbl[i].cs;
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            #1;
            chk($sformatf("tbl_rdy[%0d]", i), in_ready, tbl[i].rdy);
            chk($sformatf("tbl_pe_en[%0d]", i), pe_en, tbl[i].pe);
            chk($sformatf("tbl_busy[%0d]", i), busy, tbl[i].bsy);
            chk($sformatf("tbl_done[%0d]", i), cfg_done, tbl[i].done);
            chk($sformatf("tbl_cfgd[%0d]", i), configured, tbl[i].cfgd);
            chk($sformatf("tbl_ctrl[%0d]", i), ctrl_out, tbl[i].ctrl);
        end
        cfg_m = 1'b1;
        in_valid = 1'b0;

        // Asynchronous reset in the middle of a load.
        @(negedge clock);
        cfg_start = 1'b1;
        @(negedge clock);
        cfg_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 4'(k + 1);
            @(negedge clock);
        end
        #3 reset = 1'b0;
        #1;
        chk("arst_ctrl", ctrl_out, 0);
        chk("arst_cfgd", configured, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rdy", in_ready, 0);
        chk("arst_pe_en", pe_en, 0);
        chk("arst_done", cfg_done, 0);
        cfg_m = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        #1;
        chk("arst_rel_pe_en", pe_en, 0);
        chk("arst_rel_busy", busy, 0);
        chk("arst_rel_ctrl", ctrl_out, 0);

        load_seq(1'b1, 32'hA53C0FF0, 2, 1'b0, 32'h0, 32'hF00F3CA5);

        load_seq(1'b1, 32'h87654321, 0, 1'b1, 32'hF00F3CA5, 32'h21436587);

        // Restart after three nibbles; the nibble offered with the restart is dropped.
        @(negedge clock);
        run_en    = 1'b0;
        cfg_start = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            cfg_start = 1'b0;
            in_valid  = 1'b1;
            in_data   = 4'(4'hA + k);
            #1;
            chk($sformatf("rs_rdy[%0d]", k), in_ready, 1);
        end
        @(negedge clock);
        cfg_start = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'h7;
        #1;
        chk("rs_restart_rdy", in_ready, 0);
        chk("rs_restart_busy", busy, 1);
        chk("rs_restart_ctrl", ctrl_out, 32'h21436587);
        load_seq(1'b0, 32'h12345678, 0, 1'b0, 32'h21436587, 32'h78563412);

        // Step: one enable per rising edge of step, regardless of hold time.
        step_exp = 7'b1000001;
        @(negedge clock);
        run_en = 1'b0;
        step   = 1'b0;
        #1;
        chk("step_idle", pe_en, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            step = 1'b1;
            #1;
            chk($sformatf("step_a[%0d]", k), pe_en, (k == 0));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            step = 1'b0;
            #1;
            chk($sformatf("step_low[%0d]", k), pe_en, 0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            step = 1'b1;
            #1;
            chk($sformatf("step_b[%0d]", k), pe_en, step_exp[6-k]);
        end
        @(negedge clock);
        run_en = 1'b1;
        #1;
        chk("step_run", pe_en, 1);
        @(negedge clock);
        step   = 1'b0;
        run_en = 1'b0;
        #1;
        chk("step_end", pe_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_cfg_loader.md
# pe_cfg_loader

Configuration loader that sits directly upstream of the PE array. It receives 4-bit configuration nibbles over a valid/ready stream and assembles them into one 8-bit control word per PE in a shadow bank. When a full set has arrived, it commits the set atomically to the active bank, which drives every PE's `ctrl_signals_in`. It also generates the shared PE `en`, from a run level and a single-step request.

## Interface
- `NUM_PE`, default 4: number of PEs served; must be ≥1.
- `CTRL_W`, default 8: control word width per PE. It is fixed at 8 and equals 2 nibbles.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `cfg_start`  in  1  begins a load, or restarts a load already in progress.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a nibble this cycle.
- `in_data`  in  4  configuration nibble.
- `run_en`  in  1  level; free-run the PEs.
- `step`  in  1  level; each 0→1 edge requests exactly one PE enable cycle.
- `ctrl_out`  out  8*NUM_PE  active control words; PE i uses bits [8i+7:8i].
- `pe_en`  out  1  shared `en` to all PEs.
- `configured`  out  1  at least one full configuration has been committed.
- `cfg_done`  out  1  one-cycle pulse; the first cycle a new `ctrl_out` is visible.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, LOAD, COMMIT.
  - IDLE: `cfg_start`=1 → LOAD, nibble counter cleared to 0.
  - LOAD:
    - `cfg_start`=1 → counter cleared to 0, stay in LOAD. Partial shadow contents are retained but overwritten by the new load.
    - Otherwise each handshake (`in_valid` & `in_ready` at an edge) writes one nibble and increments the counter.
    - The handshake with counter = 2*NUM_PE−1 → COMMIT.
  - COMMIT: active bank ← shadow bank, `configured` ← 1, `cfg_done` ← 1, → IDLE. `cfg_start` is ignored in COMMIT.
- Nibble order: counter value c targets PE c/2. Even c is the high nibble [7:4]; odd c is the low nibble [3:0]. PE 0 is sent first.
- Counter width is clog2(2*NUM_PE), minimum 1; it never exceeds 2*NUM_PE−1.
- `in_ready` = (state == LOAD) & ~`cfg_start`, combinational. A nibble presented in the same cycle as a restart is not consumed.
- `ctrl_out` is the registered active bank. It is unchanged by LOAD activity; old words keep driving the PEs until COMMIT.
- Step detect: `step_q` is a registered copy of `step`. `step_pulse` = `step` & ~`step_q`.
- `pe_en` = `configured` & (`run_en` | `step_pulse`), combinational from registered `configured`. It is 0 until the first commit regardless of `run_en` or `step`.
- Loading may overlap running; `pe_en` is not gated by FSM state.

## Timing
- Reset values (asynchronous): state IDLE, counter 0, shadow 0, active 0, `ctrl_out` 0, `configured` 0, `cfg_done` 0, `step_q` 0. Consequently `in_ready` 0, `pe_en` 0, `busy` 0.
- Reset asserted mid-LOAD or mid-COMMIT aborts the load. The active bank clears to 0 and `configured` clears to 0.
- `cfg_start` sampled at edge E0 (IDLE) → `in_ready` = 1 from E0 onward (cycle after E0).
- Last handshake at edge E → COMMIT during cycle (E, E+1]. At E+1, `ctrl_out` takes the new words and `cfg_done` = 1 for exactly that one cycle. `busy` drops after E+1.
- Minimum load duration is 2*NUM_PE handshake cycles plus 1 COMMIT cycle. Gaps in `in_valid` stretch LOAD arbitrarily with no timeout.
- `step` held high for many cycles yields exactly one `pe_en` cycle. A step while `run_en` = 1 has no additional effect.
- The PE samples `ctrl_out` on edges where `pe_en` = 1. If `run_en` = 1 across a commit, the PE loads the new words at the first edge after E+1.

## Test plan
- Reset: assert `reset` = 0 mid-cycle → all outputs 0 immediately; `run_en` = 1 with `configured` = 0 → `pe_en` stays 0.
- Full load, NUM_PE = 4, nibbles A,5,3,C,0,F,F,0 back-to-back → `ctrl_out` = 32'hF00F3CA5 one edge after the 8th handshake; `cfg_done` high exactly 1 cycle; `configured` = 1.
- Backpressure and gaps: same data with `in_valid` toggling 1,0,0,1… → identical `ctrl_out`; `in_ready` = 0 in IDLE and COMMIT; no nibble is lost or duplicated.
- Restart: after 3 nibbles, pulse `cfg_start` with `in_valid` = 1 and `in_data` = 7 → that nibble is not consumed. A fresh 8 nibbles 1..8 then give `ctrl_out` = 32'h78563412.
- Overlapped reload: with `run_en` = 1 and active 32'hF00F3CA5, load 8 new nibbles → `pe_en` stays 1 throughout. `ctrl_out` holds 32'hF00F3CA5 until the commit edge, then changes in one cycle.
- Step: `configured` = 1, `run_en` = 0, `step` held high for 5 cycles → `pe_en` = 1 for exactly 1 cycle. Drop `step` and raise it again → exactly one more `pe_en` cycle.
